// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: default geometry and FSM encoding.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // True in the states where the FIFO services push/pop requests.
    function automatic logic is_op_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-MEM_LENGTH pointer counter; advances by one when en_i is high.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 3,
    parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_LENGTH - 1);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Next pointer: wrap explicitly so non-power-of-two depths work too.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external one-cycle-latency RAM.
// Optional FIFO_CTRL_ERR_EN: push-to-full / pop-from-empty raise a sticky
// error flag and park the FSM in ERROR until reset. Without it such requests
// are dropped silently.
//
// Handshake: a push is accepted (mem_write high) in IDLE/ACTIVE when the FIFO
// is not full or a pop is accepted in the same cycle; a pop is accepted
// (mem_read high) in IDLE/ACTIVE when the FIFO is not empty. Both strobes are
// combinational; valid_out follows mem_read by exactly one cycle.
module fifo_ctrl import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   th_full,
    input  logic [ADDR_WIDTH:0]   th_empty,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr_w,
    output logic [ADDR_WIDTH-1:0] mem_addr_r,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output state_t                state_o
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] th_full_q, th_empty_q;
    logic             valid_q;
    logic             op_state;
    logic             rd_acc, wr_acc;

    // Requests are only honoured in the operating states, and never while
    // reset is being applied.
    assign op_state = is_op_state(state_q) && !reset;

    assign full         = (count_q == CNT_W'(MEM_LENGTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= th_full_q);
    assign almost_empty = (count_q <= th_empty_q);

    // A push on a full FIFO is still fine if a word leaves in the same cycle.
    assign rd_acc    = op_state && pop && !empty;
    assign wr_acc    = op_state && push && (!full || rd_acc);
    assign mem_read  = rd_acc;
    assign mem_write = wr_acc;

    // Gating with reset drops a pending read return the moment reset arrives.
    assign valid_out = valid_q && !reset;
    assign count     = count_q;
    assign state_o   = state_q;

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_LENGTH (MEM_LENGTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en_i  (wr_acc),
        .ptr_o (mem_addr_w)
    );

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_LENGTH (MEM_LENGTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en_i  (rd_acc),
        .ptr_o (mem_addr_r)
    );

    // Occupancy update: simultaneous accepted push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Next state and sticky error flags.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (count_d != '0) state_d = ST_ACTIVE;
            ST_ACTIVE: if (count_d == '0) state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
        if (op_state && push && full && !pop) begin
            ovf_d   = 1'b1;
            state_d = ST_ERROR;
        end
        if (op_state && pop && empty && !push) begin
            unf_d   = 1'b1;
            state_d = ST_ERROR;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`else
    // Next state; illegal requests are simply not accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (count_d != '0) state_d = ST_ACTIVE;
            ST_ACTIVE: if (count_d == '0) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

    // State, count, thresholds and read-return registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            count_q    <= '0;
            th_full_q  <= '0;
            th_empty_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= rd_acc;
            if (state_q == ST_INIT) begin
                th_full_q  <= th_full;
                th_empty_q <= th_empty;
            end
        end
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, memory address width.
REQ-002 SHALL have parameter MEM_LENGTH, default 1<<ADDR_WIDTH, FIFO depth in words.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port push  input  1  write request from upstream.
REQ-006 SHALL have port pop  input  1  read request from downstream.
REQ-007 SHALL have port th_full  input  ADDR_WIDTH+1  almost-full threshold, sampled in INIT.
REQ-008 SHALL have port th_empty  input  ADDR_WIDTH+1  almost-empty threshold, sampled in INIT.
REQ-009 SHALL have port mem_write  output  1  write strobe to the RAM.
REQ-010 SHALL have port mem_read  output  1  read strobe to the RAM.
REQ-011 SHALL have ports mem_addr_w, mem_addr_r  output  ADDR_WIDTH  RAM write/read addresses.
REQ-012 SHALL have port valid_out  output  1  RAM data_out valid this cycle.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  ADDR_WIDTH+1  stored word count.
REQ-015 SHALL have ports overflow_err, underflow_err  output  1 each  error flags.

Function
REQ-016 SHALL implement states RESET, INIT, IDLE, ACTIVE, ERROR; RESET->INIT on reset deassert; INIT->IDLE after one cycle.
REQ-017 SHALL move IDLE->ACTIVE when count becomes nonzero and ACTIVE->IDLE when count becomes zero.
REQ-018 SHALL drive mem_write = push & accepted (combinational, same cycle) with mem_addr_w = write pointer; accepted = state in {IDLE, ACTIVE} and (!full or pop accepted same cycle).
REQ-019 SHALL drive mem_read = pop & !empty & state in {IDLE, ACTIVE} (combinational) with mem_addr_r = read pointer.
REQ-020 SHALL assert valid_out exactly one cycle after each mem_read (one-cycle RAM read latency).
REQ-021 SHALL increment pointers modulo MEM_LENGTH on each accepted access; wrap from MEM_LENGTH-1 to 0.
REQ-022 SHALL update count: +1 push only, -1 pop only, unchanged when both accepted.
REQ-023 SHALL set full = (count==MEM_LENGTH), empty = (count==0), almost_full = (count>=th_full), almost_empty = (count<=th_empty), all combinational from registered count.
REQ-024 SHALL accept push and pop together when full; no overflow flagged.
REQ-025 SHALL ignore pop when empty even with simultaneous push; push accepted, count becomes 1.
REQ-026 SHALL ignore push/pop in RESET, INIT, ERROR (strobes low).

Reset
REQ-027 SHALL, while reset high, hold state RESET, pointers 0, count 0, mem_write/mem_read/valid_out 0, empty 1, full 0, error flags 0, thresholds 0.
REQ-028 SHALL abort any in-flight valid_out when reset asserts mid-operation; no stored word survives reset.

Configuration
REQ-029 SHALL, with FIFO_CTRL_ERR_EN defined, set overflow_err on push to full without pop and underflow_err on pop to empty without push, enter ERROR, and remain there until reset.
REQ-030 SHALL, without FIFO_CTRL_ERR_EN, silently drop such requests, tie overflow_err/underflow_err to 0, and never enter ERROR.

Structure
REQ-031 SHALL take state encodings and default ADDR_WIDTH from shared package fifo_pkg.
REQ-032 SHALL instantiate sub-module fifo_ptr (modulo-MEM_LENGTH pointer counter with enable) twice, for read and write pointers.

Verification
REQ-033 SHALL cover: reset, 8 pushes -> mem_addr_w 0..7, count 8, full 1, almost_full 1 with th_full=6.
REQ-034 SHALL cover: 8 pops after fill -> mem_addr_r 0..7, valid_out one cycle after each mem_read, empty 1.
REQ-035 SHALL cover: 3 push then 8 push/pop pairs -> count stays 3, pointers wrap past 7 to 0.
REQ-036 SHALL cover: push on full with FIFO_CTRL_ERR_EN -> overflow_err 1, state ERROR, strobes low until reset.
REQ-037 SHALL cover: pop on empty without macro -> mem_read 0, underflow_err 0, count 0.
REQ-038 SHALL cover: reset asserted with count 5 -> next cycle count 0, empty 1, valid_out 0.
